// File: rtl/imem_fetch_if.sv
// Fetch/load bus between the fetch stage (master) and the instruction memory (slave).
// Carries the valid/ready fetch request, the registered response, the program-load
// write strobe and the init-complete flag. No logic, signals only.
interface imem_fetch_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic [1:0]  rsp_err;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        init_done;

  modport master (
    output req_valid, req_addr, rsp_ready, load_en, load_addr, load_data,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err, init_done
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, load_en, load_addr, load_data,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err, init_done
  );
endinterface

// File: rtl/imem_fetch.sv
// Instruction memory with valid/ready fetch port, program-load port and NOP clear sweep after reset.
// Latency: one cycle (request accepted on edge N is presented as a response after edge N).
// Backpressure: rsp_ready low while a response is held drops req_ready in the same cycle.
// Ports: clk, rst (async, active-high); bus (imem_fetch_if.slave):
//   req_valid/req_ready/req_addr           fetch request, byte address
//   rsp_valid/rsp_ready/rsp_instr/rsp_addr/rsp_err  registered response, err = {out_of_range, misaligned}
//   load_en/load_addr/load_data            program-load write, honoured only after the sweep
//   init_done                              high once every word has been cleared to NOP_WORD
// DEPTH must be a power of two and at least 4.
module imem_fetch #(
  parameter int          DEPTH    = 256,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic         clk,
  input  logic         rst,
  imem_fetch_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0] state_init = 1'b0;
  localparam logic [0:0] state_run  = 1'b1;

  logic [0:0]    state;
  logic [AW-1:0] init_idx;
  logic [31:0]   mem [DEPTH];

  logic          run;
  logic          accept;
  logic [1:0]    req_err;
  logic [AW-1:0] req_idx;
  logic          load_ok;
  logic [AW-1:0] load_idx;

  logic          rsp_valid_q;
  logic [31:0]   rsp_instr_q;
  logic [31:0]   rsp_addr_q;
  logic [1:0]    rsp_err_q;

  assign run = (state == state_run);

  // Bits above the word index must be zero; anything else is out of range rather than aliased.
  assign req_err = {((bus.req_addr >> (AW + 2)) != 32'd0), (bus.req_addr[1:0] != 2'b00)};
  assign req_idx = bus.req_addr[AW+1:2];

  assign load_ok  = run && bus.load_en && (bus.load_addr[1:0] == 2'b00)
                    && ((bus.load_addr >> (AW + 2)) == 32'd0);
  assign load_idx = bus.load_addr[AW+1:2];

  // Combinational from rsp_ready so a draining response frees the slot in the same cycle.
  assign bus.req_ready = run && (!rsp_valid_q || bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_instr = rsp_instr_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.init_done = run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= state_init;
      init_idx <= '0;
    end else if (!run) begin
      init_idx <= init_idx + AW'(1);
      if (init_idx == {AW{1'b1}}) begin
        state <= state_run;
      end
    end
  end

  // Array has no reset; the sweep owns the single write port until it finishes.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[init_idx] <= NOP_WORD;
    end else if (load_ok) begin
      mem[load_idx] <= bus.load_data;
    end
  end

  // Reading mem here with non-blocking writes gives read-before-write on a same-word collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= NOP_WORD;
      rsp_addr_q  <= 32'd0;
      rsp_err_q   <= 2'b00;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_instr_q <= (req_err != 2'b00) ? NOP_WORD : mem[req_idx];
      rsp_addr_q  <= bus.req_addr;
      rsp_err_q   <= req_err;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

endmodule
